// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared response/burst encodings and FSM state types for axi_ram_responder
package axi_ram_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_BURST} rd_state_t;
    function automatic logic burst_steps(input logic [1:0] burst);
        return burst == BURST_INCR || burst == BURST_WRAP;
    endfunction
endpackage

// File: rtl/axi_ram_responder_if.sv
// axi_ram_responder_if: AXI4 full bus between a DMA master and the RAM responder
interface axi_ram_responder_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_ram_responder_mem.sv
// axi_ram_responder_mem: simple dual-port read-first RAM with byte write enables
module axi_ram_responder_mem #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 12,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        for (int i = 0; i < STRB_WIDTH; i++)
            if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/axi_ram_responder.sv
// axi_ram_responder: AXI4 slave serving concurrent read and write bursts from an on-chip RAM
module axi_ram_responder
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 6,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input logic clk,
    input logic rstn,
    axi_ram_responder_if.slave s_axi
);
    localparam int SL = $clog2(STRB_WIDTH);
    localparam logic [2:0] FULL_SIZE = 3'(SL);
    function automatic logic [MEM_WORDS_LOG2-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return a[MEM_WORDS_LOG2+SL-1:SL];
    endfunction
    logic unused;
    assign unused = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.arlock, s_axi.arcache, s_axi.arprot};
    wr_state_t w_state, w_next;
    logic awready_q, w_size_err, aw_hs, w_hs, w_final;
    logic [ID_WIDTH-1:0] bid_q;
    logic [1:0] bresp_q, w_burst;
    logic [MEM_WORDS_LOG2-1:0] w_idx;
    logic [8:0] w_beats;
    assign aw_hs   = s_axi.awvalid && awready_q;
    assign w_hs    = w_state == W_DATA && s_axi.wvalid;
    assign w_final = w_beats == 9'd1;
    always_comb begin
        w_next = w_state;
        if (w_state == W_IDLE) w_next = aw_hs ? W_DATA : W_IDLE;
        else if (w_state == W_DATA) w_next = (w_hs && w_final) ? W_RESP : W_DATA;
        else w_next = s_axi.bready ? W_IDLE : W_RESP;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state    <= W_IDLE;
            awready_q  <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            w_size_err <= 1'b0;
            w_idx      <= '0;
            w_beats    <= '0;
            w_burst    <= BURST_INCR;
        end else begin
            w_state   <= w_next;
            awready_q <= w_next == W_IDLE;
            if (aw_hs) begin
                bid_q      <= s_axi.awid;
                w_idx      <= word_index(s_axi.awaddr);
                w_beats    <= {1'b0, s_axi.awlen} + 9'd1;
                w_burst    <= s_axi.awburst;
                w_size_err <= s_axi.awsize != FULL_SIZE;
                bresp_q    <= s_axi.awsize != FULL_SIZE ? RESP_SLVERR : RESP_OKAY;
            end else if (w_hs) begin
                w_beats <= w_beats - 9'd1;
                w_idx   <= burst_steps(w_burst) ? w_idx + 1'b1 : w_idx;
                // the beat counter ends the burst; a misplaced wlast only taints the response
                if (s_axi.wlast != w_final) bresp_q <= RESP_SLVERR;
            end
        end
    end
    rd_state_t r_state, r_next;
    logic arready_q, rvalid_q, rlast_q, ar_hs, rd_en;
    logic [ID_WIDTH-1:0] rid_q;
    logic [1:0] rresp_q, r_burst;
    logic [MEM_WORDS_LOG2-1:0] r_idx;
    logic [8:0] r_beats;
    logic [DATA_WIDTH-1:0] mem_q;
    assign ar_hs = s_axi.arvalid && arready_q;
    assign rd_en = r_beats != 9'd0 && (!rvalid_q || s_axi.rready);
    always_comb begin
        r_next = r_state;
        if (r_state == R_IDLE) r_next = ar_hs ? R_BURST : R_IDLE;
        else r_next = (rvalid_q && s_axi.rready && rlast_q) ? R_IDLE : R_BURST;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            r_idx     <= '0;
            r_beats   <= '0;
            r_burst   <= BURST_INCR;
        end else begin
            r_state   <= r_next;
            arready_q <= r_next == R_IDLE;
            if (ar_hs) begin
                rid_q   <= s_axi.arid;
                rresp_q <= s_axi.arsize != FULL_SIZE ? RESP_SLVERR : RESP_OKAY;
                r_idx   <= word_index(s_axi.araddr);
                r_beats <= {1'b0, s_axi.arlen} + 9'd1;
                r_burst <= s_axi.arburst;
            end
            if (rd_en) begin
                r_beats  <= r_beats - 9'd1;
                r_idx    <= burst_steps(r_burst) ? r_idx + 1'b1 : r_idx;
                rlast_q  <= r_beats == 9'd1;
                rvalid_q <= 1'b1;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
    axi_ram_responder_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_BITS (MEM_WORDS_LOG2),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (w_hs && !w_size_err),
        .waddr(w_idx),
        .wdata(s_axi.wdata),
        .wstrb(s_axi.wstrb),
        .re   (rd_en),
        .raddr(r_idx),
        .rdata(mem_q)
    );
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = w_state == W_DATA;
    assign s_axi.bvalid  = w_state == W_RESP;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rresp_q == RESP_SLVERR ? '0 : mem_q;
endmodule

// File: doc/axi_ram_responder.md
Name: axi_ram_responder

Overview:
AXI4 full slave that services the DMA masters' MM2S read bursts and S2MM write bursts from an on-chip byte-strobed RAM. It is the responder end of the m_axi_mm2s / m_axi_s2mm interfaces, used as the memory for loopback simulation and standalone FPGA bring-up. The read and write channels run independent FSMs over one dual-port RAM (one write port, one read port), so both directions stream concurrently at one beat per cycle.

Parameters:
DATA_WIDTH, 128, AXI data width in bits; a power of two, at least 32.
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 6, AXI ID width.
STRB_WIDTH, DATA_WIDTH/8, strobe width.
MEM_WORDS_LOG2, 12, log2 of RAM depth in DATA_WIDTH words.

Ports:
clk  in  1  clock
rstn  in  1  reset
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
s_axi_awvalid in 1; s_axi_awready out 1
s_axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/STRB_WIDTH/1/1  write data; s_axi_wready out 1
s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1  write response; s_axi_bready in 1
s_axi_arid/araddr/arlen/arsize/arburst  in  as AW  read address
s_axi_arvalid in 1; s_axi_arready out 1
s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; s_axi_rready in 1
awlock/awcache/awprot/arlock/arcache/arprot  in  1/4/3 each  accepted and ignored

Behaviour:
- Clocking and reset: single clock clk. rstn is asynchronous, active-low.
- Reset state: all ready and valid outputs are 0; bid, bresp, rid, rresp and rlast are 0; both FSMs go to IDLE. RAM contents are not reset.
- Address mapping: word index = addr[MEM_WORDS_LOG2+log2(STRB_WIDTH)-1 : log2(STRB_WIDTH)]. Upper address bits are ignored, so the index wraps modulo the depth. Low (sub-word) address bits are ignored.
- Burst types: INCR and WRAP both increment the word index by 1 per beat, and the index wraps at the RAM end. FIXED holds the index constant. Beats per burst = len+1, from 1 to 256.
- Size error: if size != log2(STRB_WIDTH), the burst is still fully handshaked. RAM is not written and read data is 0. Response is SLVERR (2'b10); otherwise OKAY (2'b00).
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, registered. On the AW handshake, latch id, index, len, burst and size error. Go to W_DATA; awready drops the next cycle.
  - W_DATA: wready=1. Each handshaked beat writes wdata under wstrb in the same cycle, decrements the beat counter and advances the index.
  - The beat counter alone ends the burst. A wlast value that does not match the final-beat position sets a sticky SLVERR. After the final beat, go to W_RESP.
  - W_RESP: bvalid=1 with the latched bid and bresp. On bready, go to W_IDLE.
  - AW is never accepted while a write burst is in progress.
- Read FSM states: R_IDLE, R_BURST.
  - R_IDLE: arready=1. On the AR handshake, latch the request and go to R_BURST.
  - RAM read enable rd_en = beats_left!=0 && (!rvalid || rready). The RAM output register is rdata, one cycle latency.
  - rvalid is set on rd_en, cleared on rready && !rd_en, and held otherwise. rdata, rid, rresp and rlast are stable while rvalid && !rready.
  - rlast=1 on the beat whose counter reaches zero.
  - Timing: AR handshake in cycle 0, first rvalid in cycle 2. With rready held high, there is one beat per cycle and no bubbles.
  - After the rlast handshake, go to R_IDLE; arready is high the next cycle.
- Read/write collision: a simultaneous read and write to the same word returns the old data (read-first).
- Reset mid-burst: the outstanding burst is dropped with no response, and beats already written remain in RAM.
- Arithmetic widths: beat counters are 9 bits; index registers are MEM_WORDS_LOG2 bits.

Decomposition:
- Package axi_ram_pkg: RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; BURST_FIXED/INCR/WRAP encodings; wr_state_t {W_IDLE,W_DATA,W_RESP}; rd_state_t {R_IDLE,R_BURST}.
- Sub-module axi_ram_responder_mem: simple dual-port synchronous RAM, read-first, with per-byte write enable from wstrb and read enable.
- The top level holds the two FSMs.

Test Plan:
- Write then read back: write 4 beats INCR at 0x100, awsize=4 for DATA_WIDTH 128 (log2 of 16 strobes), data 0..3 → bresp=OKAY. Read the same 4 beats → rdata 0..3, rlast on beat 3 only, first rvalid 2 cycles after the AR handshake.
- Read backpressure: 16-beat read with rready toggling pseudo-randomly → all 16 beats in order, rdata stable during stalls, no lost or duplicate beats.
- Partial strobes: write 0xFF..FF, then write 0x00..00 with wstrb=0x00FF → readback has the upper 8 bytes 0xFF and the lower 8 bytes 0x00.
- Protocol errors:
  - awsize=2 write → RAM unchanged, bresp=SLVERR.
  - awlen=3 with wlast on beat 1 → 4 beats consumed, bresp=SLVERR.
  - arsize=2 read → rdata=0, rresp=SLVERR.
- Concurrency and wrap: a 256-beat INCR write starting 2 words below the RAM end wraps to index 0. A simultaneous read of the same region returns old data on collided words and all-valid data afterwards.
- Reset mid-burst: assert rstn low during beat 2 of an 8-beat write → bvalid=0, awready=1 after release, and beats 0–1 are present in RAM.
